wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the ALU pipeline (stage-3 outputs: result, write select, write enable) and a multi-cycle unit (MCU) that uses a valid/ready handshake.
- The ALU path has priority. A starvation counter forces an MCU grant after STARVE_LIMIT blocked cycles.
- On a forced grant, the displaced ALU write is parked in a one-entry skid register and drained on the next cycle, while the upstream pipeline is stalled.
- Sits between the stage-3 pipeline register and the register file.

---
 rtl/wb_port_arbiter_pkg.sv | 27 ++
 rtl/wb_port_arbiter_if.sv | 40 ++++
 rtl/wb_skid_reg.sv | 55 +++++
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared definitions for the register-file write-port arbiter and the pipeline
// stage registers around it: default data/select widths, arbiter state encoding,
// starvation-counter width and a saturating-increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SEL_W_DEF  = 5;

  // Wide enough for the largest legal starvation limit (15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } arb_state_e;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the three sides of the write-port arbiter:
//   ALU side : alu_data, alu_sel, alu_we  (to arbiter), alu_stall (from arbiter)
//   MCU side : mc_valid, mc_data, mc_sel  (to arbiter), mc_ready  (from arbiter)
//   RF side  : rf_wdata, rf_wsel, rf_we   (from arbiter)
// Modports: slave = the arbiter, master = the pipeline / MCU / register file.
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) ();

  logic [DATA_W-1:0] alu_data;
  logic [SEL_W-1:0]  alu_sel;
  logic              alu_we;
  logic              alu_stall;

  logic              mc_valid;
  logic [DATA_W-1:0] mc_data;
  logic [SEL_W-1:0]  mc_sel;
  logic              mc_ready;

  logic [DATA_W-1:0] rf_wdata;
  logic [SEL_W-1:0]  rf_wsel;
  logic              rf_we;

  modport slave (
    input  alu_data, alu_sel, alu_we, mc_valid, mc_data, mc_sel,
    output alu_stall, mc_ready, rf_wdata, rf_wsel, rf_we
  );

  modport master (
    output alu_data, alu_sel, alu_we, mc_valid, mc_data, mc_sel,
    input  alu_stall, mc_ready, rf_wdata, rf_wsel, rf_we
  );

endinterface

// File: rtl/wb_skid_reg.sv
// -----------------------------------------------------------------------------
// wb_skid_reg
// One-entry holding register for a displaced ALU write (data + select + valid).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load_i           capture data_i/sel_i and set valid (wins over clear_i)
//   clear_i          drop the held entry
//   data_i, sel_i    entry to capture
//   data_o, sel_o    held entry
//   valid_o          entry present
// -----------------------------------------------------------------------------
module wb_skid_reg
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [DATA_W-1:0] data_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;

  // NOTE: the payload is reset along with valid; it is a single entry, so this
  // costs nothing and keeps a reset mid-drain from exposing a stale value.
  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      sel_q   <= sel_i;
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the stage-3 ALU result
// (priority) and a multi-cycle unit with a valid/ready handshake. After
// STARVE_LIMIT blocked MCU cycles the MCU is granted by force; a displaced ALU
// write is parked in a skid register and written in the following DRAIN cycle
// while the upstream pipeline is stalled. Writes to register 0 are dropped.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  ALU inputs / alu_stall (registered), MCU inputs / mc_ready
//                (combinational), rf_wdata/rf_wsel/rf_we (registered)
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned SEL_W        = SEL_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_port_arbiter_if.slave    bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  starve_cnt_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [SEL_W-1:0]  rf_wsel_q;
  logic              rf_we_q;
  logic              alu_stall_q;

  logic              force_grant;
  logic              mc_ready;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] skid_data;
  logic [SEL_W-1:0]  skid_sel;
  logic              skid_valid;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    force_grant = bus.mc_valid && (starve_cnt_q == LIMIT);
    mc_ready    = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    if (state_q == ST_NORMAL) begin
      mc_ready  = !bus.alu_we || force_grant;
      skid_load = force_grant && bus.alu_we;
    end else begin
      // The skid entry is written during DRAIN, so it is released here.
      skid_clear = 1'b1;
    end
  end

  wb_skid_reg #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (bus.alu_data),
    .sel_i   (bus.alu_sel),
    .data_o  (skid_data),
    .sel_o   (skid_sel),
    .valid_o (skid_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
      rf_wdata_q   <= '0;
      rf_wsel_q    <= '0;
      rf_we_q      <= 1'b0;
      alu_stall_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          alu_stall_q <= 1'b0;
          if (bus.alu_we && !force_grant) begin
            rf_wdata_q <= bus.alu_data;
            rf_wsel_q  <= bus.alu_sel;
            rf_we_q    <= (bus.alu_sel != '0);
            if (bus.mc_valid) starve_cnt_q <= sat_inc(starve_cnt_q, LIMIT);
          end else if (bus.mc_valid) begin
            // MCU transfer: either an ALU gap or a forced grant.
            rf_wdata_q   <= bus.mc_data;
            rf_wsel_q    <= bus.mc_sel;
            rf_we_q      <= (bus.mc_sel != '0);
            starve_cnt_q <= '0;
            if (bus.alu_we) begin
              // The ALU entry went into the skid register this cycle.
              state_q     <= ST_DRAIN;
              alu_stall_q <= 1'b1;
            end
          end else begin
            rf_we_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          rf_wdata_q  <= skid_data;
          rf_wsel_q   <= skid_sel;
          rf_we_q     <= skid_valid && (skid_sel != '0);
          if (bus.mc_valid) starve_cnt_q <= sat_inc(starve_cnt_q, LIMIT);
          state_q     <= ST_NORMAL;
          alu_stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mc_ready  = mc_ready;
  assign bus.alu_stall = alu_stall_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.rf_wsel   = rf_wsel_q;
  assign bus.rf_we     = rf_we_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed and random stimulus for wb_port_arbiter. A reference model predicts
// mc_ready and the next-cycle rf_*/alu_stall for every driven cycle; the
// prediction is queued and compared when the DUT output appears.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int L  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DW), .SEL_W(SW)) bus ();

  wb_port_arbiter #(
    .DATA_W       (DW),
    .SEL_W        (SW),
    .STARVE_LIMIT (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          stall;
    logic          we;
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } rf_obs_t;

  rf_obs_t sb_q[$];
  int      n_pass  = 0;
  int      n_total = 0;

  // Reference model state
  bit            m_drain;
  int            m_cnt;
  logic [SW-1:0] m_skid_sel;
  logic [DW-1:0] m_skid_data;

  // Per-step results
  bit   alu_cons;
  bit   mc_xfer;
  logic obs_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Select/data only matter when a write is issued.
  function automatic rf_obs_t mk(input logic stall, input logic we,
                                 input logic [SW-1:0] sel, input logic [DW-1:0] data);
    rf_obs_t r;
    r.stall = stall;
    r.we    = we;
    r.sel   = we ? sel  : '0;
    r.data  = we ? data : '0;
    return r;
  endfunction

  task automatic drive(input logic awe, input logic [SW-1:0] asel, input logic [DW-1:0] adata,
                       input logic mv, input logic [SW-1:0] msel, input logic [DW-1:0] mdata);
    bus.alu_we   = awe;
    bus.alu_sel  = asel;
    bus.alu_data = adata;
    bus.mc_valid = mv;
    bus.mc_sel   = msel;
    bus.mc_data  = mdata;
  endtask

  task automatic model_reset();
    m_drain = 1'b0;
    m_cnt   = 0;
    sb_q.delete();
  endtask

  // One clock cycle with the currently driven inputs: predict, check mc_ready,
  // cross the edge, check the registered outputs.
  task automatic step(input string tag);
    bit      force_g;
    bit      exp_ready;
    rf_obs_t exp_e;
    rf_obs_t got;
    alu_cons = 1'b0;
    mc_xfer  = 1'b0;
    #1;
    force_g = bus.mc_valid && (m_cnt == L);
    if (!m_drain) begin
      exp_ready = !bus.alu_we || force_g;
      if (bus.alu_we && !force_g) begin
        exp_e    = mk(1'b0, bus.alu_sel != 0, bus.alu_sel, bus.alu_data);
        alu_cons = 1'b1;
        if (bus.mc_valid && m_cnt < L) m_cnt++;
      end else if (bus.mc_valid) begin
        exp_e   = mk(bus.alu_we, bus.mc_sel != 0, bus.mc_sel, bus.mc_data);
        mc_xfer = 1'b1;
        m_cnt   = 0;
        if (bus.alu_we) begin
          m_skid_sel  = bus.alu_sel;
          m_skid_data = bus.alu_data;
          alu_cons    = 1'b1;
          m_drain     = 1'b1;
        end
      end else begin
        exp_e = mk(1'b0, 1'b0, '0, '0);
      end
    end else begin
      exp_ready = 1'b0;
      exp_e     = mk(1'b0, m_skid_sel != 0, m_skid_sel, m_skid_data);
      if (bus.mc_valid && m_cnt < L) m_cnt++;
      m_drain   = 1'b0;
    end
    sb_q.push_back(exp_e);
    obs_ready = bus.mc_ready;
    check({tag, ".mc_ready"}, 64'(obs_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    got = mk(bus.alu_stall, bus.rf_we, bus.rf_wsel, bus.rf_wdata);
    check({tag, ".rf"}, 64'(got), 64'(sb_q.pop_front()));
  endtask

  initial begin
    logic [DW-1:0] adata;
    logic          mv;
    logic          awe;
    logic [SW-1:0] asel;
    logic [SW-1:0] msel;
    logic [DW-1:0] mdata;
    bit            a_hold;
    int            wait_c;

    // ---------------- reset ----------------
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    model_reset();
    #2 rst_n = 1'b0;
    #10;
    check("reset.rf_we",     64'(bus.rf_we),     64'(0));
    check("reset.rf_wsel",   64'(bus.rf_wsel),   64'(0));
    check("reset.rf_wdata",  64'(bus.rf_wdata),  64'(0));
    check("reset.alu_stall", 64'(bus.alu_stall), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- ALU only ----------------
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
      step("alu_only");
      check("alu_only.const", 64'({bus.alu_stall, bus.rf_we, bus.rf_wsel, bus.rf_wdata}),
            64'({1'b0, 1'b1, 5'd3, 32'h11}));
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step("idle");

    // ---------------- MCU in an ALU gap ----------------
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hABCD);
    step("mc_gap");
    check("mc_gap.ready", 64'(obs_ready), 64'(1));
    check("mc_gap.rf", 64'({bus.rf_we, bus.rf_wsel, bus.rf_wdata}), 64'({1'b1, 5'd7, 32'hABCD}));
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step("idle");

    // ---------------- starvation ----------------
    adata = 32'h100;
    mv    = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(1'b1, 5'd2, adata, mv, 5'd9, 32'hBEEF);
      step("starve");
      if (cyc < 4) check("starve.blocked", 64'(obs_ready), 64'(0));
      if (cyc == 4) begin
        check("starve.forced", 64'(obs_ready), 64'(1));
        check("starve.mc_write", 64'({bus.alu_stall, bus.rf_we, bus.rf_wsel, bus.rf_wdata}),
              64'({1'b1, 1'b1, 5'd9, 32'hBEEF}));
      end
      if (cyc == 5)
        check("starve.skid_write", 64'({bus.alu_stall, bus.rf_we, bus.rf_wsel, bus.rf_wdata}),
              64'({1'b0, 1'b1, 5'd2, 32'h104}));
      if (cyc == 6)
        check("starve.after", 64'(bus.rf_wdata), 64'(32'h105));
      if (alu_cons) adata++;
      if (mc_xfer) mv = 1'b0;
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step("idle");

    // ---------------- register 0 filter ----------------
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
    step("r0_alu");
    check("r0_alu.we", 64'(bus.rf_we), 64'(0));
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    step("r0_mc");
    check("r0_mc.ready", 64'(obs_ready), 64'(1));
    check("r0_mc.we", 64'(bus.rf_we), 64'(0));
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step("idle");

    // ---------------- reset mid-DRAIN ----------------
    adata = 32'h200;
    mv    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'd2, adata, mv, 5'd9, 32'hCAFE);
      step("pre_rst");
      if (alu_cons) adata++;
      if (mc_xfer) mv = 1'b0;
      if (m_drain) break;
    end
    check("pre_rst.in_drain", 64'(bus.alu_stall), 64'(1));
    drive(1'b1, 5'd2, adata, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.rf_we",     64'(bus.rf_we),     64'(0));
    check("mid_rst.alu_stall", 64'(bus.alu_stall), 64'(0));
    check("mid_rst.rf_wdata",  64'(bus.rf_wdata),  64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst");
    check("post_rst.first", 64'({bus.rf_we, bus.rf_wdata}), 64'({1'b1, 32'h205}));
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step("post_rst.idle");
    check("post_rst.no_skid", 64'(bus.rf_we), 64'(0));

    // ---------------- random soak ----------------
    awe    = 1'b0;
    asel   = '0;
    adata  = '0;
    mv     = 1'b0;
    msel   = '0;
    mdata  = '0;
    a_hold = 1'b0;
    wait_c = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!a_hold) begin
        awe   = ($urandom_range(0, 99) < 75);
        asel  = SW'($urandom_range(0, 31));
        adata = $urandom;
      end
      if (!mv) begin
        mv    = ($urandom_range(0, 99) < 40);
        msel  = SW'($urandom_range(0, 31));
        mdata = $urandom;
      end
      drive(awe, asel, adata, mv, msel, mdata);
      step("soak");
      a_hold = awe && !alu_cons;
      if (mv) wait_c++;
      if (mc_xfer) begin
        check("soak.mc_wait_bound", 64'(wait_c > L + 1), 64'(0));
        wait_c = 0;
        mv     = 1'b0;
      end
    end
    check("soak.sb_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
